lsq_sched: RTL
==============

LSQ_SCHED -- requirements
Module: lsq_sched

Interface
REQ-001 The block SHALL have parameter C_XLEN, default 32, meaning data/address width.
REQ-002 The block SHALL have parameter C_DEPTH, default 4, meaning unified queue entries (power of 2, >=2).
REQ-003 Port clk_i  in  1  clock; all state on rising edge.
REQ-004 Port clk_en_i  in  1  global clock enable; low freezes all state.
REQ-005 Port resetb_i  in  1  reset, asynchronous, active-low.
REQ-006 Port exs_lq_wr_i  in  1  push load entry.
REQ-007 Port exs_sq_wr_i  in  1  push store entry.
REQ-008 Port exs_funct3_i  in  3  access size/sign code.
REQ-009 Port exs_regd_addr_i  in  5  load destination register.
REQ-010 Port exs_regs2_data_i  in  C_XLEN  store data.
REQ-011 Port exs_addr_i  in  C_XLEN  byte address.
REQ-012 Port exs_full_o  out  1  queue full; pushes ignored.
REQ-013 Port dmem_req_o / dmem_we_o  out  1 each  memory request / write strobe.
REQ-014 Port dmem_be_o  out  4  byte enables.
REQ-015 Port dmem_addr_o / dmem_wdata_o  out  C_XLEN each  word address / write data.
REQ-016 Port dmem_gnt_i / dmem_rvalid_i  in  1 each  request accepted / read data valid.
REQ-017 Port dmem_rdata_i  in  C_XLEN  read data.
REQ-018 Port wb_wr_o  out  1  register write-back strobe.
REQ-019 Port wb_addr_o  out  5, wb_data_o  out  C_XLEN  write-back register/data.
REQ-020 Port hvec_lmaf_o / hvec_smaf_o  out  1 each  load / store misaligned-or-illegal pulse; hvec_addr_o  out  C_XLEN  faulting address.

Function
REQ-021 The block SHALL hold a program-ordered FIFO of C_DEPTH entries {is_store, funct3, regd, addr, wdata}, one outstanding memory transaction max.
REQ-022 Push occurs on a clk_en_i cycle with exactly one of lq_wr/sq_wr high and exs_full_o low; both high or push when full SHALL leave the queue unchanged.
REQ-023 exs_full_o SHALL equal (count == C_DEPTH); simultaneous push and pop leaves count unchanged; pointers wrap modulo C_DEPTH.
REQ-024 FSM states IDLE, REQ, WAIT; dmem_req_o = (state==REQ); dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o driven from the head entry and stable while in REQ.
REQ-025 IDLE, queue non-empty: faulting head -> pulse hvec_lmaf_o (load) or hvec_smaf_o (store) for one clk_en cycle with hvec_addr_o = addr, pop, stay IDLE; else -> REQ.
REQ-026 Fault = funct3 illegal (loads legal: 000,001,010,100,101; stores: 000,001,010), or halfword with addr[0]=1, or word with addr[1:0]!=0.
REQ-027 REQ: gnt & store -> pop, IDLE; gnt & load -> WAIT; no gnt -> hold REQ.
REQ-028 WAIT: rvalid -> pop, IDLE, and next cycle wb_wr_o=1 for one clk_en cycle with wb_addr_o=regd and wb_data_o = rdata >> 8*addr[1:0], sign-extended (000,001) or zero-extended (100,101) to size.
REQ-029 gnt outside REQ and rvalid outside WAIT SHALL be ignored.
REQ-030 dmem_addr_o = {addr[C_XLEN-1:2], 2'b00}; dmem_be_o: byte 4'b0001<<addr[1:0], half 4'b0011<<addr[1:0], word 4'b1111 (loads and stores).
REQ-031 dmem_wdata_o: byte replicated x4, halfword replicated x2, word unchanged.
REQ-032 Minimum latency: push in cycle N -> dmem_req_o in cycle N+2; fault pulse in cycle N+2.

Reset
REQ-033 On resetb_i low all outputs SHALL be 0, FSM IDLE, count and pointers 0; an in-flight transaction is abandoned and produces no write-back.

Verification
REQ-034 SW addr 0x104 data 0xDEADBEEF, gnt immediate -> req at N+2, we=1, addr 0x104, be=4'hF, wdata 0xDEADBEEF, queue empty after.
REQ-035 LB addr 0x103, rdata 0x80000000 -> be=4'b1000, wb_data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-036 SH addr 0x2 data 0x1234ABCD -> be=4'b1100, wdata 0xABCDABCD.
REQ-037 gnt=0, 4 pushes -> exs_full_o=1, 5th push ignored; release gnt -> 4 transactions issued in push order.
REQ-038 LW addr 0x102 -> hvec_lmaf_o one-cycle pulse, hvec_addr_o 0x102, no dmem_req_o, entry popped.
REQ-039 Reset asserted in WAIT -> all outputs 0; later rvalid causes no wb_wr_o.

Source files
------------

// File: rtl/lsq_sched.sv
// Unified in-order load/store queue feeding a single-outstanding data-memory port.
// Faulting heads raise a one-cycle exception pulse instead of a memory access; loads write back one cycle after rvalid.
module lsq_sched #(
    parameter int C_XLEN  = 32,
    parameter int C_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              clk_en_i,
    input  logic              resetb_i,
    input  logic              exs_lq_wr_i,
    input  logic              exs_sq_wr_i,
    input  logic [2:0]        exs_funct3_i,
    input  logic [4:0]        exs_regd_addr_i,
    input  logic [C_XLEN-1:0] exs_regs2_data_i,
    input  logic [C_XLEN-1:0] exs_addr_i,
    output logic              exs_full_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [3:0]        dmem_be_o,
    output logic [C_XLEN-1:0] dmem_addr_o,
    output logic [C_XLEN-1:0] dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [C_XLEN-1:0] dmem_rdata_i,
    output logic              wb_wr_o,
    output logic [4:0]        wb_addr_o,
    output logic [C_XLEN-1:0] wb_data_o,
    output logic              hvec_lmaf_o,
    output logic              hvec_smaf_o,
    output logic [C_XLEN-1:0] hvec_addr_o
);
    localparam int C_PW = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1;
    localparam logic [C_PW-1:0] C_PTR_ONE  = 1;
    localparam logic [C_PW:0]   C_CNT_ONE  = 1;
    localparam logic [C_PW:0]   C_CNT_FULL = (C_PW+1)'(C_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    logic              r_is_store [C_DEPTH];
    logic [2:0]        r_funct3   [C_DEPTH];
    logic [4:0]        r_regd     [C_DEPTH];
    logic [C_XLEN-1:0] r_addr     [C_DEPTH];
    logic [C_XLEN-1:0] r_wdata    [C_DEPTH];

    state_t            r_state, w_state_nxt;
    logic [C_PW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [C_PW:0]     r_count;
    logic              r_lmaf, r_smaf, r_wb_wr;
    logic [4:0]        r_wb_addr;
    logic [C_XLEN-1:0] r_wb_data, r_hvec_addr;

    logic              w_push, w_pop, w_fault, w_lmaf, w_smaf, w_wb, w_in_req;
    logic              w_h_st;
    logic [2:0]        w_h_f3;
    logic [4:0]        w_h_regd;
    logic [C_XLEN-1:0] w_h_addr, w_h_wdata, w_shift, w_ld_data, w_wdata_rep;
    logic [3:0]        w_be;

    assign w_h_st    = r_is_store[r_rd_ptr];
    assign w_h_f3    = r_funct3[r_rd_ptr];
    assign w_h_regd  = r_regd[r_rd_ptr];
    assign w_h_addr  = r_addr[r_rd_ptr];
    assign w_h_wdata = r_wdata[r_rd_ptr];

    assign exs_full_o = (r_count == C_CNT_FULL);
    assign w_push     = (exs_lq_wr_i ^ exs_sq_wr_i) & ~exs_full_o;
    assign w_in_req   = (r_state == S_REQ);

    always_comb begin
        w_fault = 1'b0;
        case (w_h_f3)
            3'b000:         w_fault = 1'b0;
            3'b001:         w_fault = w_h_addr[0];
            3'b010:         w_fault = |w_h_addr[1:0];
            3'b100, 3'b101: w_fault = w_h_st | (w_h_f3[0] & w_h_addr[0]);
            default:        w_fault = 1'b1;
        endcase
    end

    always_comb begin
        w_be        = 4'hF;
        w_wdata_rep = w_h_wdata;
        case (w_h_f3[1:0])
            2'b00: begin
                w_be        = 4'b0001 << w_h_addr[1:0];
                w_wdata_rep = {(C_XLEN/8){w_h_wdata[7:0]}};
            end
            2'b01: begin
                w_be        = 4'b0011 << w_h_addr[1:0];
                w_wdata_rep = {(C_XLEN/16){w_h_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Read data arrives word-aligned; shift the addressed lane down before extending.
    assign w_shift = dmem_rdata_i >> {w_h_addr[1:0], 3'b000};
    always_comb begin
        w_ld_data = w_shift;
        case (w_h_f3)
            3'b000:  w_ld_data = {{(C_XLEN-8){w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_ld_data = {{(C_XLEN-16){w_shift[15]}}, w_shift[15:0]};
            3'b100:  w_ld_data = {{(C_XLEN-8){1'b0}}, w_shift[7:0]};
            3'b101:  w_ld_data = {{(C_XLEN-16){1'b0}}, w_shift[15:0]};
            default: w_ld_data = w_shift;
        endcase
    end

    assign dmem_req_o   = w_in_req;
    assign dmem_we_o    = w_in_req & w_h_st;
    assign dmem_be_o    = w_in_req ? w_be : 4'b0000;
    assign dmem_addr_o  = w_in_req ? {w_h_addr[C_XLEN-1:2], 2'b00} : '0;
    assign dmem_wdata_o = w_in_req ? w_wdata_rep : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_lmaf      = 1'b0;
        w_smaf      = 1'b0;
        w_wb        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    if (w_fault) begin
                        w_pop  = 1'b1;
                        w_lmaf = ~w_h_st;
                        w_smaf = w_h_st;
                    end else begin
                        w_state_nxt = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (dmem_gnt_i) begin
                    if (w_h_st) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (dmem_rvalid_i) begin
                    w_pop       = 1'b1;
                    w_wb        = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (clk_en_i && w_push) begin
            r_is_store[r_wr_ptr] <= exs_sq_wr_i;
            r_funct3[r_wr_ptr]   <= exs_funct3_i;
            r_regd[r_wr_ptr]     <= exs_regd_addr_i;
            r_addr[r_wr_ptr]     <= exs_addr_i;
            r_wdata[r_wr_ptr]    <= exs_regs2_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_lmaf      <= 1'b0;
            r_smaf      <= 1'b0;
            r_hvec_addr <= '0;
            r_wb_wr     <= 1'b0;
            r_wb_addr   <= '0;
            r_wb_data   <= '0;
        end else if (clk_en_i) begin
            r_state <= w_state_nxt;
            if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: ;
            endcase
            r_lmaf      <= w_lmaf;
            r_smaf      <= w_smaf;
            r_hvec_addr <= (w_lmaf | w_smaf) ? w_h_addr : '0;
            r_wb_wr     <= w_wb;
            r_wb_addr   <= w_wb ? w_h_regd : 5'd0;
            r_wb_data   <= w_wb ? w_ld_data : '0;
        end
    end

    assign wb_wr_o     = r_wb_wr;
    assign wb_addr_o   = r_wb_addr;
    assign wb_data_o   = r_wb_data;
    assign hvec_lmaf_o = r_lmaf;
    assign hvec_smaf_o = r_smaf;
    assign hvec_addr_o = r_hvec_addr;
endmodule
